muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide unit. Sits beside the single-cycle ALU in the execute stage and covers the M-extension ops the ALU does not implement.
- The core decode drives `start` / `op` / operands and stalls the PC while `busy` is high.
- The unit returns the result with a one-cycle `done` pulse, plus a `zero` flag with the same meaning as the ALU's flag.
- Fixed latency; one operation in flight at a time.

---
 rtl/muldiv_unit.sv | 160 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one op in flight, fixed XLEN+3 cycle latency.
// Shift-add multiply and restoring divide share one accumulator; signs are fixed up after the loop.
module muldiv_unit #(
    parameter int XLEN = 32,
    parameter int CW   = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            zero
);
    typedef enum logic [2:0] {
        S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE
    } state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [XLEN-1:0]     a_q, a_d, b_q, b_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN:0]       rem_q, rem_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                neg_q, neg_d, rneg_q, rneg_d;
    logic                div0_q, div0_d, ovf_q, ovf_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic                is_div, sa_en, sb_en, sign_a, sign_b;
    logic [XLEN-1:0]     mag_a, mag_b;
    logic [XLEN:0]       mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0]   prod_s;
    logic [XLEN-1:0]     quo_s, rem_s, mul_res, div_res, fix_res;

    always_comb begin
        is_div = op_q[2];
        sa_en  = (op_q == 3'b001) || (op_q == 3'b010) || (op_q == 3'b100) || (op_q == 3'b110);
        sb_en  = (op_q == 3'b001) || (op_q == 3'b100) || (op_q == 3'b110);
        sign_a = sa_en & a_q[XLEN-1];
        sign_b = sb_en & b_q[XLEN-1];
        mag_a  = sign_a ? -a_q : a_q;
        mag_b  = sign_b ? -b_q : b_q;

        // Multiply step: conditional add into the high half, carry kept, then shift right.
        mul_sum = acc_q[0] ? ({1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q})
                           : {1'b0, acc_q[2*XLEN-1:XLEN]};
        // Divide step: dividend bits stream out of the top of acc low half, quotient bits in at the bottom.
        div_shift = {rem_q[XLEN-1:0], acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_q};

        prod_s  = neg_q ? -acc_q : acc_q;
        mul_res = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        quo_s   = neg_q  ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_s   = rneg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
        div_res = op_q[1] ? rem_s : quo_s;
        if (div0_q)
            fix_res = op_q[1] ? a_q : '1;
        else if (ovf_q)
            fix_res = op_q[1] ? '0 : a_q;
        else
            fix_res = is_div ? div_res : mul_res;
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        div0_d   = div0_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                opnd_d  = is_div ? mag_b : mag_a;
                acc_d   = {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
                rem_d   = '0;
                cnt_d   = '0;
                neg_d   = sign_a ^ sign_b;
                rneg_d  = sign_a;
                div0_d  = is_div && (b_q == '0);
                ovf_d   = is_div && !op_q[0] && (a_q == MIN_NEG) && (b_q == '1);
                state_d = S_RUN;
            end
            S_RUN: begin
                if (is_div) begin
                    rem_d = div_diff[XLEN] ? div_shift : div_diff;
                    acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], ~div_diff[XLEN]};
                end else begin
                    acc_d = {mul_sum, acc_q[XLEN-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(XLEN-1))
                    state_d = S_FIX;
            end
            S_FIX: begin
                result_d = fix_res;
                state_d  = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            div0_q   <= div0_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign zero   = (result_q == '0);
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: results, fixed latency, busy/done timing, abort on reset.
module tb_muldiv_unit;
    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

    logic        clk, rst_n, start, busy, done, zero;
    logic [2:0]  op;
    logic [31:0] a, b, result;
    int          checks, errors;

    muldiv_unit #(.XLEN(32), .CW(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .zero(zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_idle();
        for (int n = 0; n < 50 && busy; n++) @(negedge clk);
    endtask

    // Drives one op and returns its result, the edge count from accept to done, and busy right after accept.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] r, output int lat, output logic bsy1);
        wait_idle();
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; bsy1 = busy;
        op = ~o; a = ~x; b = ~y;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (done) begin lat = n; break; end
        end
        r = result;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        #12;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL reset_state got busy=%b done=%b result=%h zero=%b exp 0 0 00000000 1",
                     busy, done, result, zero);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_mul_basic();
        logic [31:0] r; int lat; logic b1;
        run_op(MUL, 32'd7, 32'hFFFFFFFD, r, lat, b1);
        checks++;
        if (b1 !== 1'b1) begin errors++; $display("FAIL mul_busy_after_accept got %b exp 1", b1); end
        checks++;
        if (lat !== 34) begin errors++; $display("FAIL mul_latency got %0d exp 34", lat); end
        checks++;
        if (r !== 32'hFFFFFFEB || zero !== 1'b0) begin
            errors++; $display("FAIL mul_result got %h zero=%b exp ffffffeb zero=0", r, zero);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== 32'hFFFFFFEB) begin
            errors++;
            $display("FAIL mul_after_done got done=%b busy=%b result=%h exp 0 0 ffffffeb", done, busy, result);
        end
    endtask

    task automatic test_vectors();
        logic [2:0]  ops [13];
        logic [31:0] va  [13];
        logic [31:0] vb  [13];
        logic [31:0] exp [13];
        logic [31:0] r; int lat; logic b1;
        ops = '{MULH, MULHU, MULHSU, DIV, REM, DIVU, REMU, DIV, REMU, DIV, REM, DIVU, REM};
        va  = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9,
                32'hFFFFFFF9, 32'h00001234, 32'h00001234, 32'h80000000, 32'h80000000, 32'h00001234,
                32'h00001234};
        vb  = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd2, 32'd2, 32'd0, 32'd0,
                32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
        exp = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFC,
                32'h00000001, 32'hFFFFFFFF, 32'h00001234, 32'h80000000, 32'h00000000, 32'hFFFFFFFF,
                32'h00001234};
        for (int i = 0; i < 13; i++) begin
            run_op(ops[i], va[i], vb[i], r, lat, b1);
            checks++;
            if (r !== exp[i] || lat !== 34 || zero !== (exp[i] == 32'h0)) begin
                errors++;
                $display("FAIL vec%0d op=%b a=%h b=%h got %h lat=%0d zero=%b exp %h lat=34",
                         i, ops[i], va[i], vb[i], r, lat, zero, exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic early; int lat;
        wait_idle();
        @(negedge clk);
        start = 1'b1; op = DIVU; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0; early = 1'b0;
        for (int n = 1; n <= 33; n++) begin
            @(posedge clk); #1;
            if (done) early = 1'b1;
            if (n >= 2 && n <= 20) begin
                start = (n % 2 == 0); op = MUL; a = $urandom; b = $urandom;
            end else if (n >= 30) begin
                start = 1'b1; op = MUL; a = 32'd6; b = 32'd7;
            end else begin
                start = 1'b0;
            end
        end
        @(posedge clk); #1;
        checks++;
        if (early || done !== 1'b1 || result !== 32'd14) begin
            errors++;
            $display("FAIL b2b_first got early=%b done=%b result=%h exp early=0 done=1 result=0000000e",
                     early, done, result);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_done_start_ignored got busy=%b exp 0", busy); end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_second_accept got busy=%b exp 1", busy); end
        start = 1'b0; a = '0; b = '0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (done) begin lat = n; break; end
        end
        checks++;
        if (lat !== 34 || result !== 32'd42) begin
            errors++; $display("FAIL b2b_second got %h lat=%0d exp 0000002a lat=34", result, lat);
        end
    endtask

    task automatic test_reset_abort();
        int pulses; logic [31:0] r; int lat; logic b1;
        wait_idle();
        @(negedge clk);
        start = 1'b1; op = DIV; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #3; rst_n = 1'b0; #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL abort_state got busy=%b done=%b result=%h zero=%b exp 0 0 00000000 1",
                     busy, done, result, zero);
        end
        @(negedge clk); rst_n = 1'b1;
        pulses = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (done || busy) pulses++;
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL abort_no_done got %0d active cycles exp 0", pulses); end
        run_op(MUL, 32'd3, 32'd5, r, lat, b1);
        checks++;
        if (r !== 32'h0000000F || lat !== 34) begin
            errors++; $display("FAIL abort_fresh_mul got %h lat=%0d exp 0000000f lat=34", r, lat);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        test_reset();
        test_mul_basic();
        test_vectors();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
